// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame receiver: sync word,
// receiver states, frame word slots and waveform encoding.
package spi_frame_pkg;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'h0000_FFFF;

  typedef enum logic {HUNT, RECV} rx_state_t;

  // Slot of each 32-bit word inside one frame, in transmission order.
  localparam logic [1:0] WORD_PRD1 = 2'd0;
  localparam logic [1:0] WORD_PRD2 = 2'd1;
  localparam logic [1:0] WORD_PRD3 = 2'd2;
  localparam logic [1:0] WORD_CTRL = 2'd3;

  typedef enum logic [1:0] {
    WF_SQUARE = 2'd0,
    WF_SAW    = 2'd1,
    WF_TRI    = 2'd2,
    WF_SINE   = 2'd3
  } waveform_t;

  // A control word is accepted only when every reserved bit is zero.
  function automatic logic ctrl_ok(input logic [31:0] ctrl);
    return ctrl[31:4] == 28'd0;
  endfunction

endpackage

// File: rtl/spi_frame_receiver_sync_edge.sv
// Two-flop synchronizer for one asynchronous pin, plus a third flop that
// turns the synchronized level into a single-cycle rising-edge strobe.
module sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], d};
  end

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI frame receiver: hunts for the sync word, stages three period words and
// a control word, then publishes the whole note set in a single cycle.
module spi_frame_receiver
  import spi_frame_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD      = SYNC_WORD_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter int          TO_W           = 17
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sck,
  input  logic        sdi,
  output logic [31:0] prd1,
  output logic [31:0] prd2,
  output logic [31:0] prd3,
  output logic [1:0]  waveform,
  output logic [1:0]  notes,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        locked
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic sck_rise;
  logic sck_level_unused;
  logic sdi_s;
  logic sdi_rise_unused;

  sync_edge u_sck_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sck),
    .level   (sck_level_unused),
    .rise    (sck_rise)
  );

  sync_edge u_sdi_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sdi),
    .level   (sdi_s),
    .rise    (sdi_rise_unused)
  );

  rx_state_t         state_q,       state_d;
  logic [31:0]       shift_q,       shift_d;
  logic [4:0]        bit_cnt_q,     bit_cnt_d;
  logic [1:0]        word_idx_q,    word_idx_d;
  logic [TO_W-1:0]   to_cnt_q,      to_cnt_d;
  logic [3:0][31:0]  staging_q,     staging_d;
  logic              shifted_q,     shifted_d;
  logic              commit_q,      commit_d;
  logic [31:0]       prd1_q,        prd1_d;
  logic [31:0]       prd2_q,        prd2_d;
  logic [31:0]       prd3_q,        prd3_d;
  waveform_t         waveform_q,    waveform_d;
  logic [1:0]        notes_q,       notes_d;
  logic              frame_valid_q, frame_valid_d;
  logic              frame_err_q,   frame_err_d;

  logic [31:0]       rx_word;
  logic [TO_W-1:0]   to_next;

  assign rx_word = {shift_q[30:0], sdi_s};
  assign to_next = to_cnt_q + TO_W'(1);

  // NOTE: every signal assigned here gets its default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    word_idx_d    = word_idx_q;
    to_cnt_d      = to_cnt_q;
    staging_d     = staging_q;
    shifted_d     = sck_rise;
    commit_d      = 1'b0;
    prd1_d        = prd1_q;
    prd2_d        = prd2_q;
    prd3_d        = prd3_q;
    waveform_d    = waveform_q;
    notes_d       = notes_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    if (sck_rise) begin
      shift_d = rx_word;
    end

    unique case (state_q)
      HUNT: begin
        // Only a fresh shift can complete the sync word; stale register
        // contents left over from an earlier frame never re-trigger a lock.
        if (shifted_q && shift_q == SYNC_WORD) begin
          state_d    = RECV;
          bit_cnt_d  = '0;
          word_idx_d = '0;
          to_cnt_d   = '0;
        end
      end

      RECV: begin
        if (commit_q) begin
          state_d = HUNT;
          if (ctrl_ok(staging_q[WORD_CTRL])) begin
            prd1_d        = staging_q[WORD_PRD1];
            prd2_d        = staging_q[WORD_PRD2];
            prd3_d        = staging_q[WORD_PRD3];
            waveform_d    = waveform_t'(staging_q[WORD_CTRL][1:0]);
            notes_d       = staging_q[WORD_CTRL][3:2];
            frame_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (sck_rise) begin
          // An accepted bit always wins over a timeout expiring this cycle.
          bit_cnt_d = bit_cnt_q + 5'd1;
          to_cnt_d  = '0;
          if (bit_cnt_q == 5'd31) begin
            staging_d[word_idx_q] = rx_word;
            word_idx_d            = word_idx_q + 2'd1;
            commit_d              = (word_idx_q == WORD_CTRL);
          end
        end else if (to_next == TO_LIMIT) begin
          state_d     = HUNT;
          frame_err_d = 1'b1;
          to_cnt_d    = '0;
          staging_d   = '0;
        end else begin
          to_cnt_d = to_next;
        end
      end

      default: state_d = HUNT;
    endcase
  end

  // NOTE: the staging words are cleared on reset as well, because a timeout
  // discard and a partial frame must never leak old data into a commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= HUNT;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      word_idx_q    <= '0;
      to_cnt_q      <= '0;
      staging_q     <= '0;
      shifted_q     <= 1'b0;
      commit_q      <= 1'b0;
      prd1_q        <= '0;
      prd2_q        <= '0;
      prd3_q        <= '0;
      waveform_q    <= WF_SQUARE;
      notes_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      word_idx_q    <= word_idx_d;
      to_cnt_q      <= to_cnt_d;
      staging_q     <= staging_d;
      shifted_q     <= shifted_d;
      commit_q      <= commit_d;
      prd1_q        <= prd1_d;
      prd2_q        <= prd2_d;
      prd3_q        <= prd3_d;
      waveform_q    <= waveform_d;
      notes_q       <= notes_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign prd1        = prd1_q;
  assign prd2        = prd2_q;
  assign prd3        = prd3_q;
  assign waveform    = waveform_q;
  assign notes       = notes_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign locked      = (state_q == RECV);

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Randomized self-checking bench for spi_frame_receiver; a note-set model
// tracks what the oscillators should see after every frame.
module tb_spi_frame_receiver;

  localparam int          TO    = 2000;
  localparam int          TOW   = 11;
  localparam logic [31:0] SYNC  = 32'h0000_FFFF;
  localparam int          SLAT  = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sck = 1'b0;
  logic        sdi = 1'b0;
  logic [31:0] prd1, prd2, prd3;
  logic [1:0]  waveform, notes;
  logic        frame_valid, frame_err, locked;

  spi_frame_receiver #(
    .SYNC_WORD      (SYNC),
    .TIMEOUT_CYCLES (TO),
    .TO_W           (TOW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sck         (sck),
    .sdi         (sdi),
    .prd1        (prd1),
    .prd2        (prd2),
    .prd3        (prd3),
    .waveform    (waveform),
    .notes       (notes),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int unsigned vld_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned both_cnt = 0;
  int unsigned last_err_cyc = 0;
  int unsigned last_rise_cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // Reference note set, updated only by whole accepted frames.
  logic [31:0] m_prd1 = '0, m_prd2 = '0, m_prd3 = '0;
  logic [1:0]  m_wf = '0, m_notes = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid) vld_cnt <= vld_cnt + 1;
    if (frame_err) begin
      err_cnt      <= err_cnt + 1;
      last_err_cyc <= cyc;
    end
    if (frame_valid && frame_err) both_cnt <= both_cnt + 1;
  end

  function automatic logic [99:0] obs_vec();
    return {prd1, prd2, prd3, waveform, notes};
  endfunction

  function automatic logic [99:0] exp_vec();
    return {m_prd1, m_prd2, m_prd3, m_wf, m_notes};
  endfunction

  task automatic model_frame(input logic [31:0] p1, p2, p3, ctrl);
    if (ctrl[31:4] == 28'd0) begin
      m_prd1  = p1;
      m_prd2  = p2;
      m_prd3  = p3;
      m_wf    = ctrl[1:0];
      m_notes = ctrl[3:2];
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One SPI bit at sck = clk/8: data set while sck is low, then a rise.
  task automatic send_bit(input logic b);
    sdi = b;
    sck = 1'b0;
    tick(4);
    sck = 1'b1;
    last_rise_cyc = cyc;
    tick(4);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_frame(input logic [31:0] p1, p2, p3, ctrl);
    send_word(SYNC);
    send_word(p1);
    send_word(p2);
    send_word(p3);
    send_word(ctrl);
    tick(2);
  endtask

  task automatic check_frame(input string name, input logic [31:0] ctrl,
                             input int unsigned v0, input int unsigned e0);
    int unsigned want_v;
    int unsigned want_e;
    want_v = (ctrl[31:4] == 28'd0) ? 1 : 0;
    want_e = 1 - want_v;
    n_checks++;
    if (obs_vec() !== exp_vec())
      $display("FAIL %s fields: got %h expected %h", name, obs_vec(), exp_vec());
    else n_pass++;
    n_checks++;
    if (vld_cnt - v0 !== want_v)
      $display("FAIL %s valid_pulses: got %0d expected %0d", name, vld_cnt - v0, want_v);
    else n_pass++;
    n_checks++;
    if (err_cnt - e0 !== want_e)
      $display("FAIL %s err_pulses: got %0d expected %0d", name, err_cnt - e0, want_e);
    else n_pass++;
    n_checks++;
    if (locked !== 1'b0)
      $display("FAIL %s locked_after: got %b expected 0", name, locked);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    n_checks++;
    if (obs_vec() !== 100'd0) $display("FAIL reset_fields: got %h expected 0", obs_vec());
    else n_pass++;
    n_checks++;
    if ({locked, frame_valid, frame_err} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000", {locked, frame_valid, frame_err});
    else n_pass++;
  endtask

  task automatic test_noise_sync();
    logic [36:0] noise;
    logic [31:0] sh;
    logic [31:0] w;
    bit          clean;
    int unsigned v0, e0;
    // Draw noise that cannot itself spell the sync word after a zeroed shifter.
    for (int t = 0; t < 64; t++) begin
      noise = {$urandom_range(0, 31), $urandom};
      sh = '0;
      clean = 1'b1;
      for (int i = 36; i >= 0; i--) begin
        sh = {sh[30:0], noise[i]};
        if (sh == SYNC) clean = 1'b0;
      end
      if (clean) break;
    end
    v0 = vld_cnt;
    e0 = err_cnt;
    for (int i = 36; i >= 0; i--) begin
      send_bit(noise[i]);
      n_checks++;
      if (locked !== 1'b0) $display("FAIL noise_locked bit %0d: got %b expected 0", i, locked);
      else n_pass++;
    end
    w = SYNC;
    for (int i = 31; i >= 0; i--) begin
      send_bit(w[i]);
      n_checks++;
      if (locked !== (i == 0))
        $display("FAIL sync_locked bit %0d: got %b expected %b", i, locked, (i == 0));
      else n_pass++;
    end
    send_word(32'h0001_5F90);
    send_word(32'h0001_1170);
    send_word(32'h0000_E9A0);
    send_word(32'h0000_000D);
    tick(2);
    model_frame(32'h0001_5F90, 32'h0001_1170, 32'h0000_E9A0, 32'h0000_000D);
    check_frame("noise_then_frame", 32'h0000_000D, v0, e0);
  endtask

  task automatic test_nominal();
    int unsigned v0, e0;
    // Clear the published set first so the nominal frame must rewrite it.
    send_frame(32'd1, 32'd2, 32'd3, 32'h0);
    model_frame(32'd1, 32'd2, 32'd3, 32'h0);
    v0 = vld_cnt;
    e0 = err_cnt;
    send_frame(32'h0001_5F90, 32'h0001_1170, 32'h0000_E9A0, 32'h0000_000D);
    model_frame(32'h0001_5F90, 32'h0001_1170, 32'h0000_E9A0, 32'h0000_000D);
    n_checks++;
    if (obs_vec() !== {32'd90000, 32'd70000, 32'd59808, 2'd1, 2'd3})
      $display("FAIL nominal_literal: got %h expected 90000/70000/59808/1/3", obs_vec());
    else n_pass++;
    check_frame("nominal", 32'h0000_000D, v0, e0);
  endtask

  task automatic test_random_frames();
    logic [31:0] p1, p2, p3, ctrl;
    int unsigned v0, e0;
    for (int k = 0; k < 8; k++) begin
      p1 = $urandom;
      p2 = $urandom;
      p3 = $urandom;
      if ($urandom_range(0, 3) == 0)
        ctrl = {28'($urandom_range(1, 32'h0FFF_FFFF)), 4'($urandom)};
      else
        ctrl = {28'd0, 4'($urandom)};
      v0 = vld_cnt;
      e0 = err_cnt;
      send_frame(p1, p2, p3, ctrl);
      model_frame(p1, p2, p3, ctrl);
      check_frame($sformatf("random_%0d", k), ctrl, v0, e0);
    end
  endtask

  task automatic test_bad_ctrl();
    int unsigned v0, e0;
    v0 = vld_cnt;
    e0 = err_cnt;
    send_frame($urandom, $urandom, $urandom, 32'h0000_0105);
    check_frame("bad_ctrl", 32'h0000_0105, v0, e0);
  endtask

  task automatic test_sync_in_data();
    logic [31:0] p1, p3;
    int unsigned v0, e0;
    int          drops;
    logic [31:0] w;
    p1 = $urandom;
    p3 = $urandom;
    v0 = vld_cnt;
    e0 = err_cnt;
    drops = 0;
    send_word(SYNC);
    send_word(p1);
    w = SYNC;
    for (int i = 31; i >= 0; i--) begin
      send_bit(w[i]);
      if (locked !== 1'b1) drops++;
    end
    send_word(p3);
    send_word(32'h0000_0006);
    tick(2);
    n_checks++;
    if (drops != 0) $display("FAIL sync_data_lock_drops: got %0d expected 0", drops);
    else n_pass++;
    model_frame(p1, SYNC, p3, 32'h0000_0006);
    check_frame("sync_in_data", 32'h0000_0006, v0, e0);
  endtask

  task automatic test_timeout();
    int unsigned v0, e0;
    logic [31:0] p1, p2, p3;
    logic [7:0]  extra;
    v0 = vld_cnt;
    e0 = err_cnt;
    extra = 8'($urandom);
    send_word(SYNC);
    send_word($urandom);
    for (int i = 7; i >= 0; i--) send_bit(extra[i]);
    sck = 1'b0;
    tick(TO + 5);
    n_checks++;
    if (err_cnt - e0 !== 1) $display("FAIL timeout_err_pulses: got %0d expected 1", err_cnt - e0);
    else n_pass++;
    // The timeout runs from the cycle the last edge leaves the synchronizer.
    n_checks++;
    if (last_err_cyc - last_rise_cyc !== TO + SLAT)
      $display("FAIL timeout_latency: got %0d expected %0d", last_err_cyc - last_rise_cyc, TO + SLAT);
    else n_pass++;
    n_checks++;
    if (obs_vec() !== exp_vec() || vld_cnt != v0 || locked !== 1'b0)
      $display("FAIL timeout_hold: got %h/%0d/%b expected %h/0/0", obs_vec(), vld_cnt - v0, locked, exp_vec());
    else n_pass++;
    p1 = $urandom;
    p2 = $urandom;
    p3 = $urandom;
    v0 = vld_cnt;
    e0 = err_cnt;
    send_frame(p1, p2, p3, 32'h0000_000B);
    model_frame(p1, p2, p3, 32'h0000_000B);
    check_frame("after_timeout", 32'h0000_000B, v0, e0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] p1, p2, p3;
    int unsigned v0, e0;
    p1 = $urandom | 32'h1;
    p2 = $urandom | 32'h1;
    p3 = $urandom | 32'h1;
    send_frame(p1, p2, p3, 32'h0000_000F);
    model_frame(p1, p2, p3, 32'h0000_000F);
    send_word(SYNC);
    send_word($urandom);
    send_word($urandom);
    send_word($urandom);
    n_checks++;
    if (locked !== 1'b1) $display("FAIL pre_reset_locked: got %b expected 1", locked);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    m_prd1 = '0; m_prd2 = '0; m_prd3 = '0; m_wf = '0; m_notes = '0;
    #1;
    n_checks++;
    if (obs_vec() !== exp_vec() || locked !== 1'b0)
      $display("FAIL async_reset: got %h locked %b expected 0 locked 0", obs_vec(), locked);
    else n_pass++;
    sck = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    p1 = $urandom;
    p2 = $urandom;
    p3 = $urandom;
    v0 = vld_cnt;
    e0 = err_cnt;
    send_frame(p1, p2, p3, 32'h0000_0009);
    model_frame(p1, p2, p3, 32'h0000_0009);
    check_frame("after_reset", 32'h0000_0009, v0, e0);
  endtask

  initial begin
    test_reset();
    test_noise_sync();
    test_nominal();
    test_random_frames();
    test_bad_ctrl();
    test_sync_in_data();
    test_timeout();
    test_reset_mid();
    n_checks++;
    if (both_cnt != 0) $display("FAIL valid_err_overlap: got %0d cycles expected 0", both_cnt);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_frame_receiver.md
Name: spi_frame_receiver

Overview:
- Upstream stage of the waveform generators and output mixer, between the PIC SPI link and the note/oscillator datapath.
- Brings the SPI pins (sck, sdi) into the system clk domain.
- Hunts for the frame sync word, assembles one frame of three period words plus one control word, and validates the control word.
- Publishes all four fields atomically, so the oscillators never see a partially updated note set.

Parameters:
- SYNC_WORD, 32'h0000_FFFF, frame delimiter sent by the PIC before every frame.
- TIMEOUT_CYCLES, 100000, clk cycles with no sck rising edge before a frame in progress is aborted.
- TO_W, 17, timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; sck frequency must not exceed clk/4.
- reset_n  input  1  asynchronous, active-low reset.
- sck  input  1  SPI clock from PIC, asynchronous to clk.
- sdi  input  1  SPI data from PIC; MSB first; stable around sck rising edge.
- prd1  output  32  period of note 1, in clk cycles; 0 means silent.
- prd2  output  32  period of note 2.
- prd3  output  32  period of note 3.
- waveform  output  2  waveform select: 0 square, 1 sawtooth, 2 triangle, 3 sine.
- notes  output  2  number of active notes, 0..3.
- frame_valid  output  1  one-cycle pulse when new fields are committed.
- frame_err  output  1  one-cycle pulse on control-word reject or timeout.
- locked  output  1  high while in RECV (sync found, frame in progress).

Behaviour:
- Reset (async assert, sync release internally is not required): all outputs 0; state HUNT; shift register, bit counter, word index, timeout counter and staging registers all 0; synchronizer flops 0.
- Synchronization: sck and sdi each pass through two flops. A third sck flop forms the rising-edge detect; sck_rise = s2 & ~s3.
- Input latency: a pin-level sck rise is acted on 3 clk cycles later, using the sdi sample from the same synchronizer stage.
- On each sck_rise: shift_reg <= {shift_reg[30:0], sdi_s}.
- State HUNT:
  - Shift on every sck_rise.
  - On the cycle after a shift that leaves shift_reg == SYNC_WORD, go to RECV with bit_cnt=0, word_idx=0, timeout counter cleared.
  - locked=0 in HUNT.
- State RECV:
  - locked=1.
  - Each sck_rise increments bit_cnt (5-bit, wraps 31->0) and clears the timeout counter.
  - When the shift that makes bit_cnt wrap completes, the word {shift_reg[30:0], sdi_s} is written to staging[word_idx], and word_idx increments.
  - Words 0,1,2 are prd1..prd3; word 3 is control.
  - Control layout: [1:0] waveform, [3:2] notes, [31:4] must be zero.
- Commit (word 3 captured):
  - If control[31:4] == 0: on the next clk cycle prd1..prd3, waveform and notes load from staging simultaneously, and frame_valid=1 for exactly that cycle. State returns to HUNT.
  - Otherwise: outputs are unchanged, frame_err pulses for 1 cycle, state returns to HUNT.
- Timeout: in RECV, the timeout counter increments every clk cycle without sck_rise. On reaching TIMEOUT_CYCLES, pulse frame_err, go to HUNT and discard staging. Outputs keep their last committed values.
- The shift register is not cleared on a return to HUNT. A sync word overlapping the tail of an aborted frame is therefore still detected.
- The sync word is never matched in RECV: the data words may contain 0x0000FFFF.
- Simultaneous events: a sck_rise in the same cycle the timeout threshold is reached takes priority; the bit is accepted and the counter is cleared.
- Reset mid-frame: state returns to HUNT and all outputs return to 0 immediately.
- frame_valid and frame_err are never high in the same cycle.

Decomposition:
- Package spi_frame_pkg holds:
  - SYNC_WORD default;
  - typedef enum logic {HUNT, RECV} rx_state_t;
  - localparams WORD_PRD1=0, WORD_PRD2=1, WORD_PRD3=2, WORD_CTRL=3;
  - waveform encoding constants WF_SQUARE, WF_SAW, WF_TRI, WF_SINE.
- Sub-module sync_edge: 2-flop synchronizer plus rising-edge detect, with async active-low reset. Instanced for sck (edge output used) and sdi (level output only).

Test Plan:
- Nominal frame:
  - Stimulus: sck at clk/8; send 0x0000FFFF, 0x0001_5F90, 0x0001_1170, 0x0000_E9A0, 0x0000_000D.
  - Response: one frame_valid pulse; prd1=90000, prd2=70000, prd3=59808, waveform=1, notes=3; frame_err never high.
- Noise before sync:
  - Stimulus: 37 random bits, then the nominal frame.
  - Response: locked stays 0 until the 32nd sync bit; the committed values are identical to the nominal-frame case.
- Bad control word:
  - Stimulus: a valid frame with control 0x0000_0105.
  - Response: frame_err pulses; prd1..prd3, waveform and notes keep their previous values; state returns to HUNT (locked=0).
- Timeout:
  - Stimulus: send sync plus 40 bits, then hold sck low for TIMEOUT_CYCLES+5 clk cycles, then send a full valid frame.
  - Response: frame_err pulses exactly TIMEOUT_CYCLES cycles after the last edge; the second frame commits correctly.
- Sync word inside data:
  - Stimulus: a frame with prd2=0x0000FFFF.
  - Response: prd2=0x0000FFFF is committed; no resync occurs mid-frame.
- Reset mid-frame:
  - Stimulus: drop reset_n after word 2 of a frame following a previously committed frame.
  - Response: all outputs are 0 asynchronously and locked=0; after release, a fresh frame commits normally.
